// File: rtl/zbb_bist_pkg.sv
// Shared Zbb encodings, FSM/command types and the LFSR/MISR step functions for zbb_bist.
// Purely combinational helpers; no state.
package zbb_bist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
  } cmd_t;

  localparam logic [6:0]  OP_REG     = 7'b0110011;
  localparam logic [6:0]  OP_IMM     = 7'b0010011;
  localparam logic [6:0]  F7_LOGN    = 7'b0100000;
  localparam logic [6:0]  F7_MINMAX  = 7'b0000101;
  localparam logic [6:0]  F7_BASE    = 7'b0000000;
  localparam logic [2:0]  F3_ANDN    = 3'b111;
  localparam logic [2:0]  F3_ORN     = 3'b110;
  localparam logic [2:0]  F3_XNOR    = 3'b100;
  localparam logic [2:0]  F3_MAX     = 3'b110;
  localparam logic [2:0]  F3_MAXU    = 3'b111;
  localparam logic [2:0]  F3_MIN     = 3'b100;
  localparam logic [2:0]  F3_MINU    = 3'b101;
  localparam logic [2:0]  F3_ADD     = 3'b000;
  localparam logic [2:0]  F3_UNARY   = 3'b001;
  localparam logic [11:0] IMM_CLZ    = 12'h600;
  localparam logic [11:0] IMM_CTZ    = 12'h601;
  localparam logic [11:0] IMM_CPOP   = 12'h602;
  localparam logic [11:0] IMM_SEXTB  = 12'h604;

  localparam logic [3:0]  LAST_SLOT  = 4'd11;
  // x^32+x^22+x^2+x+1, left-shifting Galois form
  localparam logic [31:0] LFSR_TAPS  = 32'h0040_0007;
  localparam logic [31:0] OPND_MASK  = 32'h5A5A_5A5A;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
  endfunction

  function automatic logic [31:0] rs2_of(input logic [31:0] l);
    return {l[15:0], l[31:16]} ^ OPND_MASK;
  endfunction

  function automatic cmd_t r_cmd(input logic [6:0] f7, input logic [2:0] f3);
    return '{op: OP_REG, f3: f3, f7: f7, imm: {f7, 5'b0}};
  endfunction

  function automatic cmd_t i_cmd(input logic [11:0] imm);
    return '{op: OP_IMM, f3: F3_UNARY, f7: imm[11:5], imm: imm};
  endfunction

endpackage

// File: rtl/zbb_bist_lfsr.sv
// Operand LFSR and response MISR for zbb_bist; both update on the clock edge they are enabled.
// Seed load beats step, clear beats fold.
module zbb_bist_lfsr
  import zbb_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2D5B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic        lfsr_step,
  input  logic        misr_clear,
  input  logic        misr_en,
  input  logic [31:0] misr_data,
  output logic [31:0] lfsr,
  output logic [31:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '0;
      sig  <= '0;
    end else begin
      if (seed_load)      lfsr <= SEED;
      else if (lfsr_step) lfsr <= lfsr_next(lfsr);
      if (misr_clear)     sig  <= '0;
      else if (misr_en)   sig  <= misr_next(sig, misr_data);
    end
  end

endmodule

// File: rtl/zbb_bist.sv
// BIST initiator for the Zbb unit: 12 encodings per LFSR operand pair, responses folded into a MISR.
// Two cycles per slot (DRIVE, SAMPLE); start is ignored while busy.
module zbb_bist
  import zbb_bist_pkg::*;
#(
  parameter int          NUM_ROUNDS   = 16,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2D5B,
  parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [31:0] bist_rs1,
  output logic [31:0] bist_rs2,
  output logic [6:0]  bist_cmdOp,
  output logic [2:0]  bist_cmdF3,
  output logic [6:0]  bist_cmdF7,
  output logic [11:0] bist_immI,
  input  logic [31:0] zbb_dout,
  input  logic        zbb_isZbb,
  input  logic        zbb_regWrite
);

  localparam int RW = $clog2(NUM_ROUNDS + 1);

  function automatic cmd_t slot_cmd(input logic [3:0] s);
    cmd_t c;
    c = '0;
    case (s)
      4'd0:    c = r_cmd(F7_LOGN,   F3_ANDN);
      4'd1:    c = r_cmd(F7_LOGN,   F3_ORN);
      4'd2:    c = r_cmd(F7_LOGN,   F3_XNOR);
      4'd3:    c = i_cmd(IMM_CLZ);
      4'd4:    c = i_cmd(IMM_CTZ);
      4'd5:    c = i_cmd(IMM_CPOP);
      4'd6:    c = r_cmd(F7_MINMAX, F3_MAX);
      4'd7:    c = r_cmd(F7_MINMAX, F3_MAXU);
      4'd8:    c = r_cmd(F7_MINMAX, F3_MIN);
      4'd9:    c = r_cmd(F7_MINMAX, F3_MINU);
      4'd10:   c = i_cmd(IMM_SEXTB);
      4'd11:   c = r_cmd(F7_BASE,   F3_ADD);
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t        state;
  logic [3:0]    slot;
  logic [RW-1:0] round;
  cmd_t          cmd;
  logic [31:0]   lfsr;
  logic [31:0]   misr_data;
  logic [31:0]   opnd_nxt;
  logic          seed_load;
  logic          wrap;
  logic          last;

  assign seed_load = start && (state == S_IDLE || state == S_DONE);
  assign wrap      = (slot == LAST_SLOT);
  assign last      = wrap && (round == RW'(NUM_ROUNDS - 1));
  assign misr_data = zbb_dout ^ {30'b0, zbb_isZbb, zbb_regWrite};
  // Operands for the next DRIVE must match the LFSR value after this edge
  assign opnd_nxt  = wrap ? lfsr_next(lfsr) : lfsr;

  zbb_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .lfsr_step  (state == S_SAMPLE && wrap),
    .misr_clear (seed_load),
    .misr_en    (state == S_SAMPLE),
    .misr_data  (misr_data),
    .lfsr       (lfsr),
    .sig        (signature)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      slot     <= '0;
      round    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      cmd      <= '0;
      bist_rs1 <= '0;
      bist_rs2 <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_DRIVE;
            slot     <= '0;
            round    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            cmd      <= slot_cmd(4'd0);
            bist_rs1 <= LFSR_SEED;
            bist_rs2 <= rs2_of(LFSR_SEED);
          end
        end
        S_DRIVE: state <= S_SAMPLE;
        S_SAMPLE: begin
          if (last) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (misr_next(signature, misr_data) == EXPECTED_SIG);
            cmd      <= '0;
            bist_rs1 <= '0;
            bist_rs2 <= '0;
          end else begin
            state    <= S_DRIVE;
            slot     <= wrap ? 4'd0 : slot + 4'd1;
            round    <= wrap ? round + RW'(1) : round;
            cmd      <= slot_cmd(wrap ? 4'd0 : slot + 4'd1);
            bist_rs1 <= opnd_nxt;
            bist_rs2 <= rs2_of(opnd_nxt);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bist_cmdOp = cmd.op;
  assign bist_cmdF3 = cmd.f3;
  assign bist_cmdF7 = cmd.f7;
  assign bist_immI  = cmd.imm;

endmodule
